// File: rtl/count_enable_gen_pkg.sv
// Shared types and helpers for the lab counter front end.
// Debounce state encoding plus a width helper used by several lab blocks.
package count_enable_gen_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int CLOG2_MIN1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and debounce FSM for a bouncing push-button.
// press_event is combinational with the PRESS_WAIT -> PRESSED transition.
module btn_debounce
  import count_enable_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_event,
  output logic btn_level
);

  localparam int CW = CLOG2_MIN1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          btn_s;
  db_state_e     state_q;
  db_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;

  assign btn_s = s2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_event = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = PRESSED;
          press_event = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A re-press here is still the same press: no new event.
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    level_d = (state_d == PRESSED) ||
              (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/count_enable_gen.sv
// Enable-pulse source for the 4-bit lab counter.
// Step mode: one pulse per debounced press; free-run: prescaled tick.
module count_enable_gen
  import count_enable_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIV             = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic mode,
  output logic en,
  output logic btn_level
);

  localparam int PW = CLOG2_MIN1(DIV);
  localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

  logic          press_event;
  logic          mode_r_q;
  logic          mode_r_d;
  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          tick_q;
  logic          tick_d;
  logic          en_q;
  logic          en_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .press_event(press_event),
    .btn_level  (btn_level)
  );

  always_comb begin
    mode_r_d = mode;
    pcnt_d   = '0;
    tick_d   = 1'b0;
    if (mode_r_q) begin
      if (pcnt_q == PCNT_MAX) begin
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
    // Presses seen while free-running are dropped, not queued.
    en_d = mode_r_q ? tick_q : press_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r_q <= 1'b0;
      pcnt_q   <= '0;
      tick_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      mode_r_q <= mode_r_d;
      pcnt_q   <= pcnt_d;
      tick_q   <= tick_d;
      en_q     <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen with N=4, DIV=5.
// A clean press is table-driven; corner cases are hand-written sequences.
module tb_count_enable_gen;

  localparam int N   = 4;
  localparam int DIV = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       mode = 1'b0;
  logic       en;
  logic       btn_level;
  logic [3:0] cnt4;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic btn;
    logic en;
    logic lvl;
  } vec_t;

  vec_t vecs[30];

  count_enable_gen #(
    .DEBOUNCE_CYCLES(N),
    .DIV            (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .mode     (mode),
    .en       (en),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  // Reference 4-bit lab counter driven by en.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt4 <= 4'd0;
    else if (en) cnt4 <= cnt4 + 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    btn  = 1'b0;
    mode = 1'b0;
    step();
    step();
    chk("rst_en", en, 0);
    chk("rst_lvl", btn_level, 0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic seen;
    logic lvl_drop;

    // btn sampled 1 by s1 at edges 1..20, 0 from edge 21.
    for (int e = 1; e <= 30; e++) begin
      vecs[e-1].btn = (e <= 20);
      vecs[e-1].en  = (e == 7);
      vecs[e-1].lvl = (e >= 7) && (e <= 26);
    end

    do_reset();

    for (int i = 0; i < 30; i++) begin
      btn = vecs[i].btn;
      step();
      chk($sformatf("press_e%0d_en", i + 1),
          en, vecs[i].en);
      chk($sformatf("press_e%0d_lvl", i + 1),
          btn_level, vecs[i].lvl);
    end

    // Alternating bounce, then a 3-cycle pulse.
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      btn = (i < 4) && (i % 2 == 0);
      step();
      seen |= en | btn_level;
    end
    chk("bounce", seen, 0);
    seen = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= en | btn_level;
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen |= en | btn_level;
    end
    chk("short_pulse", seen, 0);

    // Re-press during RELEASE_WAIT.
    btn = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("repress_first_en", en, 1);
    chk("repress_first_lvl", btn_level, 1);
    for (int i = 0; i < 3; i++) step();
    seen = 1'b0;
    lvl_drop = 1'b0;
    btn = 1'b0;
    step();
    seen |= en;
    lvl_drop |= ~btn_level;
    step();
    seen |= en;
    lvl_drop |= ~btn_level;
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= en;
      lvl_drop |= ~btn_level;
    end
    chk("repress_no_en", seen, 0);
    chk("repress_lvl_held", lvl_drop, 0);
    btn = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("repress_released", btn_level, 0);

    // Press completes in the first cycle of free-run: dropped.
    btn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    mode = 1'b1;
    step();
    step();
    chk("modeedge_en", en, 0);
    chk("modeedge_lvl", btn_level, 1);
    for (int i = 7; i <= 11; i++) begin
      step();
      chk($sformatf("modeedge_k%0d_en", i),
          en, (i == 11));
    end
    btn = 1'b0;

    // Free-run from a clean reset, button pressed meanwhile.
    do_reset();
    mode = 1'b1;
    step();
    for (int e = 1; e <= 22; e++) begin
      if (e == 2) btn = 1'b1;
      step();
      chk($sformatf("free_e%0d_en", e), en,
          (e == 6 || e == 11 || e == 16 || e == 21));
    end

    // Mode 1 -> 0 mid-period, then back to 1.
    mode = 1'b0;
    btn  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= en;
    end
    chk("mode_off_no_en", seen, 0);
    mode = 1'b1;
    step();
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("mode_on_m%0d_en", i),
          en, (i == 6));
    end

    // Asynchronous reset while a press pulse is out.
    mode = 1'b0;
    for (int i = 0; i < 3; i++) step();
    btn = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("rstmid_pre_en", en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_async_en", en, 0);
    chk("rstmid_async_lvl", btn_level, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      step();
      chk($sformatf("rstmid_k%0d_en", i),
          en, (i == 6));
      chk($sformatf("rstmid_k%0d_lvl", i),
          btn_level, (i >= 6));
    end
    btn = 1'b0;

    // End-to-end with the lab counter.
    do_reset();
    mode = 1'b1;
    step();
    for (int e = 1; e <= 80; e++) step();
    chk("e2e_cnt_e80", cnt4, 15);
    step();
    chk("e2e_cnt_e81", cnt4, 15);
    step();
    chk("e2e_cnt_wrap", cnt4, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/count_enable_gen.md
# count_enable_gen

Generates the single-cycle enable pulses that drive the 4-bit lab counter's `en` input. It sits directly upstream of the counter and takes a raw, bouncing push-button plus a mode switch. In step mode it emits exactly one pulse per debounced press; in free-run mode it emits a periodic pulse from a prescaler. Its `en` output connects straight to the counter's `en`, and both blocks share the same `clk` and `rst`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change; must be ≥1.
- `DIV`, default 12500000: free-run pulse period in clk cycles; must be ≥1.
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `btn`, input, 1: raw push-button, asynchronous to `clk`, active-high, may bounce.
- `mode`, input, 1: 0 = step, 1 = free-run; synchronous to `clk`.
- `en`, output, 1: registered one-cycle enable pulse to the counter.
- `btn_level`, output, 1: registered debounced button level.

## Operation
- Synchronizer: 2 FFs, `s1 <= btn`, `s2 <= s1`. Define `btn_s = s2`. No other logic samples `btn` directly.
- Debounce FSM uses states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a stability counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`, minimum 1. N = `DEBOUNCE_CYCLES`.
  - IDLE: if `btn_s`=1, go to PRESS_WAIT with `cnt`=0.
  - PRESS_WAIT:
    - if `btn_s`=0, go to IDLE (bounce rejected);
    - else if `cnt`==N-1, go to PRESSED and raise a press event;
    - else `cnt`++.
  - PRESSED: if `btn_s`=0, go to RELEASE_WAIT with `cnt`=0.
  - RELEASE_WAIT:
    - if `btn_s`=1, go back to PRESSED with no new event;
    - else if `cnt`==N-1, go to IDLE;
    - else `cnt`++.
- `btn_level` is 1 exactly when the state is PRESSED or RELEASE_WAIT.
- `mode_r <= mode` every edge. All mode decisions use `mode_r`.
- Prescaler `pcnt`, width `$clog2(DIV)`, minimum 1:
  - held at 0 while `mode_r`=0;
  - while `mode_r`=1, increments each edge and wraps to 0 on the edge where `pcnt`==DIV-1, raising a tick on that edge.
- `en` is registered:
  - `en <= (mode_r==0) ? press_event : tick`;
  - press events that occur while `mode_r`=1 are discarded, not queued.
- With DIV=1, `en` is continuously 1 while in free-run mode.

## Timing
- Reset values: `s1`=`s2`=0, state IDLE, `cnt`=0, `pcnt`=0, `mode_r`=0, `en`=0, `btn_level`=0.
- Step-mode latency: let edge k be the first edge at which `s1` samples `btn`=1, with `btn` stable afterwards.
  - PRESSED is entered at edge k+N+2.
  - `en`=1 for exactly the one cycle following edge k+N+2.
  - `btn_level` rises at the same edge.
- Release latency: `btn_level` falls at edge j+N+2, where j is the first edge at which `s1` samples 0.
- Free-run: the first `en` comes DIV+1 edges after the edge where `mode` is sampled 1. Pulses then repeat every DIV edges.
- Boundary conditions:
  - Any bounce shorter than N stable cycles produces no `en`.
  - A re-press during RELEASE_WAIT produces no `en`.
  - A mode change 1→0 clears `pcnt` on the next edge. A tick coinciding with `mode_r`=0 cannot occur.
  - A press completing on the same edge that `mode_r` becomes 1 is discarded.
  - Reset mid-press returns to IDLE. If `btn` is still held after reset release, a fresh press is detected N+2 edges after `s1` samples 1.
  - The `cnt` and `pcnt` wrap-around is exact: there is never an off-by-one extra cycle.

## Structure
- The shared package/header holds:
  - the FSM state encoding constants IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3;
  - a `CLOG2_MIN1` width helper, reused by other lab blocks.
- Sub-module `btn_debounce`: synchronizer plus FSM, parameter `DEBOUNCE_CYCLES`, outputs `press_event` (1-cycle, combinational with the transition) and `btn_level`.
- The top level holds `mode_r`, the prescaler and the `en` register.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DIV`=5.
- Clean press in step mode (`mode`=0): `btn` rises before edge 10 and is held 20 cycles → `en` high only in the cycle after edge 16; `btn_level` 1 from edge 16; `btn_level` falls 6 edges after release.
- Bounce: `btn` toggles 1,0,1,0 on alternate cycles, then stays 0 → `en` never asserts and `btn_level` stays 0. Then a 3-cycle pulse → still no `en`.
- Free-run: `mode`=1 sampled at edge 0 → `en` pulses after edges 6, 11, 16, 21, each exactly one cycle wide. A button press during free-run produces no extra pulse.
- Mode switching: `mode` goes 1→0 mid-period → no further `en`. `mode` back to 1 → the first pulse comes DIV+1 edges later.
- Reset mid-operation: assert `rst` while `btn` is held in PRESSED → all outputs 0 immediately (asynchronous). Deassert with `btn` still 1 → one `en` pulse at N+2 edges after `s1` samples 1.
- End-to-end: connect to the 4-bit counter, free-run with `DIV`=5 for 80 edges → count reaches 15, then wraps to 0.
